// File: rtl/fc_sequencer.sv
// rtl/fc_sequencer.sv - time-shared single-multiplier fully-connected layer sequencer
//
// Purpose: computes output_vector[j] = (sum_i featuremap[i]*connect_matrix[i][j]) >>> BITWIDTH
//   one product per clock in the MAC state, then holds the result until the consumer accepts it.
// Configuration: define FC_SATURATE_EN to clamp each result to the signed BITWIDTH range;
//   left undefined, each result keeps the low BITWIDTH bits (two's-complement wrap).
// Ports:
//   clk            - rising-edge clock
//   rst            - asynchronous active-high reset
//   start          - request one matrix-vector product (honoured in IDLE only)
//   featuremap     - N_IN signed operands, held stable by the producer while busy
//   connect_matrix - N_IN x N_OUT signed weights, [i][j] multiplies featuremap[i] for output j
//   out_ready      - consumer accepts the held result
//   busy           - high in MAC
//   out_valid      - high in HOLD, result complete and stable
//   output_vector  - N_OUT registered signed results
module fc_sequencer #(
  parameter int BITWIDTH = 32,
  parameter int N_IN     = 10,
  parameter int N_OUT    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [BITWIDTH-1:0] featuremap     [N_IN],
  input  logic signed [BITWIDTH-1:0] connect_matrix [N_IN][N_OUT],
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       out_valid,
  output logic signed [BITWIDTH-1:0] output_vector  [N_OUT]
);

  localparam int IW = $clog2(N_IN);
  localparam int JW = $clog2(N_OUT);
  localparam int PW = 2 * BITWIDTH;
  // Five guard bits cover the sum of up to 16 full-scale products without overflow.
  localparam int AW = PW + 5;

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              i_q, i_d;
  logic [JW-1:0]              j_q, j_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic signed [BITWIDTH-1:0] out_vec_q [N_OUT];
  logic signed [BITWIDTH-1:0] out_vec_d [N_OUT];

  logic signed [PW-1:0]       prod;
  logic signed [AW-1:0]       sum;
  logic signed [BITWIDTH-1:0] reduced;

  // The one multiplier: operands are sign-extended so the product is the exact signed result.
  assign prod = PW'(featuremap[i_q]) * PW'(connect_matrix[i_q][j_q]);
  assign sum  = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

`ifdef FC_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted = sum >>> BITWIDTH;
    if (shifted > SAT_MAX) begin
      reduced = SAT_MAX[BITWIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      reduced = SAT_MIN[BITWIDTH-1:0];
    end else begin
      reduced = shifted[BITWIDTH-1:0];
    end
  end
`else
  // Low BITWIDTH bits of (sum >>> BITWIDTH) are exactly these bits of sum.
  assign reduced = sum[PW-1:BITWIDTH];
`endif

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    out_vec_d = out_vec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        if (i_q == I_LAST) begin
          out_vec_d[j_q] = reduced;
          acc_d          = '0;
          i_d            = '0;
          if (j_q == J_LAST) begin
            j_d     = '0;
            state_d = S_HOLD;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = sum;
          i_d   = i_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        out_vec_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      out_vec_q <= out_vec_d;
    end
  end

  assign busy          = (state_q == S_MAC);
  assign out_valid     = (state_q == S_HOLD);
  assign output_vector = out_vec_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// tb/tb_fc_sequencer.sv - self-checking bench for fc_sequencer
module tb_fc_sequencer;

  localparam int BW   = 32;
  localparam int NI   = 10;
  localparam int NO   = 10;
  localparam int LAT  = NI * NO;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 out_ready;
  logic signed [BW-1:0] fm  [NI];
  logic signed [BW-1:0] w   [NI][NO];
  logic                 busy;
  logic                 out_valid;
  logic signed [BW-1:0] ov  [NO];
  logic signed [BW-1:0] exp_vec [NO];

  int n_assert = 0;
  int n_fail   = 0;

  fc_sequencer #(.BITWIDTH(BW), .N_IN(NI), .N_OUT(NO)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .featuremap     (fm),
    .connect_matrix (w),
    .out_ready      (out_ready),
    .busy           (busy),
    .out_valid      (out_valid),
    .output_vector  (ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact wide sum of products, shift, then wrap or clamp.
  task automatic model();
    logic signed [127:0] s;
    logic signed [127:0] sh;
    for (int j = 0; j < NO; j++) begin
      s = '0;
      for (int i = 0; i < NI; i++) begin
        s = s + 128'(fm[i]) * 128'(w[i][j]);
      end
      sh = s >>> BW;
`ifdef FC_SATURATE_EN
      if (sh > 128'sh7FFFFFFF)       exp_vec[j] = 32'sh7FFFFFFF;
      else if (sh < -128'sh80000000) exp_vec[j] = 32'sh80000000;
      else                           exp_vec[j] = sh[BW-1:0];
`else
      exp_vec[j] = sh[BW-1:0];
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int j = 0; j < NO; j++) begin
      chk($sformatf("%s_out%0d", tag, j), 64'(ov[j]), 64'(exp_vec[j]));
    end
  endtask

  task automatic fill(input logic signed [BW-1:0] fv, input logic signed [BW-1:0] wv);
    for (int i = 0; i < NI; i++) begin
      fm[i] = fv;
      for (int j = 0; j < NO; j++) w[i][j] = wv;
    end
  endtask

  // Start, count edges until out_valid and busy cycles, check results, then release.
  task automatic run(input string tag);
    int cycles;
    int busy_cnt;
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    while (!out_valid && cycles < 3 * LAT) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
    end
    chk({tag, "_latency"}, 64'(cycles), 64'(LAT));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    chk({tag, "_busy_in_hold"}, 64'(busy), 64'(0));
    check_outputs(tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    tick();
    check_outputs({tag, "_idle"});
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    fill('0, '0);
    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    for (int j = 0; j < NO; j++) exp_vec[j] = '0;
    check_outputs("reset");
    rst = 1'b0;
    tick();

    // All ones in Q16: every output = 10.
    fill(32'sd65536, 32'sd65536);
    run("unity");

    // Diagonal weights: output j = j.
    fill('0, '0);
    for (int i = 0; i < NI; i++) begin
      fm[i]   = 32'(i * 65536);
      w[i][i] = 32'sd65536;
    end
    run("diag");

    // Negative single term: arithmetic shift gives -1.
    fill('0, '0);
    fm[0] = -32'sd65536;
    for (int j = 0; j < NO; j++) w[0][j] = 32'sd65536;
    run("neg");

    // Full-scale positive: wraps to 0x7FFFFFF6 or clamps to 0x7FFFFFFF.
    fill(32'sh7FFFFFFF, 32'sh7FFFFFFF);
    run("maxval");

    // Full-scale negative operands against positive weights: clamps low when saturating.
    fill(32'sh80000000, 32'sh7FFFFFFF);
    run("minval");

    // Randomized vectors, full range and small range.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) begin
        fm[i] = $urandom;
        for (int j = 0; j < NO; j++) w[i][j] = $urandom;
      end
      run($sformatf("rand_full%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) begin
        fm[i] = 32'($urandom_range(0, 1 << 20)) - 32'sd524288;
        for (int j = 0; j < NO; j++) w[i][j] = 32'($urandom_range(0, 1 << 20)) - 32'sd524288;
      end
      run($sformatf("rand_small%0d", r));
    end

    // Reset in the middle of MAC aborts at once; next start runs a full sequence.
    fill(32'sd65536, 32'sd65536);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    chk("mid_busy_before_rst", 64'(busy), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    for (int j = 0; j < NO; j++) exp_vec[j] = '0;
    check_outputs("abort");
    tick();
    rst = 1'b0;
    tick();
    run("after_abort");

    // HOLD with out_ready low: result held, start ignored, then release to IDLE.
    fill(32'sd65536, 32'sd65536);
    for (int i = 0; i < NI; i++) fm[i] = 32'((i + 1) * 65536);
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT) tick();
    chk("hold_entry_valid", 64'(out_valid), 64'(1));
    for (int c = 0; c < 20; c++) begin
      start = (c % 5 == 2);
      tick();
      chk($sformatf("hold%0d_valid", c), 64'(out_valid), 64'(1));
      chk($sformatf("hold%0d_busy", c), 64'(busy), 64'(0));
      check_outputs($sformatf("hold%0d", c));
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_exit_valid", 64'(out_valid), 64'(0));
    chk("hold_exit_busy", 64'(busy), 64'(0));
    tick();
    chk("idle_stays_busy", 64'(busy), 64'(0));
    check_outputs("idle_after_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, width of operands and results.
REQ-002 SHALL have parameter N_IN, default 10, input feature count; N_IN range 2..16.
REQ-003 SHALL have parameter N_OUT, default 10, output count; N_OUT range 2..16.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have start  input  1  request to compute one matrix-vector product.
REQ-007 SHALL have featuremap  input  signed BITWIDTH x [N_IN]  input vector.
REQ-008 SHALL have connect_matrix  input  signed BITWIDTH x [N_IN][N_OUT]  weights, element [i][j] multiplies featuremap[i] for output j.
REQ-009 SHALL have out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have busy  output  1  high while in MAC state.
REQ-011 SHALL have out_valid  output  1  result vector complete and held.
REQ-012 SHALL have output_vector  output  signed BITWIDTH x [N_OUT]  registered results.

Function
REQ-013 SHALL implement states IDLE, MAC, HOLD with exactly one signed BITWIDTH x BITWIDTH multiplier, time-shared.
REQ-014 SHALL leave IDLE for MAC when start is high at a rising edge in IDLE, clearing i, j and the accumulator; start SHALL be ignored in MAC and HOLD.
REQ-015 SHALL, in each MAC cycle, add featuremap[i]*connect_matrix[i][j] to a signed accumulator of width 2*BITWIDTH+5, then increment i.
REQ-016 SHALL, on the MAC cycle with i = N_IN-1, write output_vector[j] = (accumulator + current product) arithmetically shifted right by BITWIDTH, reduced to BITWIDTH per REQ-025/026; then clear accumulator, set i=0, increment j.
REQ-017 SHALL, on the MAC cycle with i = N_IN-1 and j = N_OUT-1, transition to HOLD.
REQ-018 SHALL take exactly N_IN*N_OUT MAC cycles (100 at defaults); start sampled at edge k gives out_valid high after edge k+N_IN*N_OUT.
REQ-019 SHALL assert out_valid only in HOLD; HOLD SHALL exit to IDLE at the first edge with out_ready high, out_valid falling after that edge.
REQ-020 SHALL keep output_vector stable in HOLD and IDLE; entries change only on their write cycle in MAC.
REQ-021 SHALL rely on featuremap and connect_matrix being held stable by the producer while busy is high; inputs are not captured.

Reset
REQ-022 SHALL, on rst high, immediately force state IDLE, busy=0, out_valid=0, all output_vector entries=0, i=0, j=0, accumulator=0.
REQ-023 SHALL abort any computation in progress on rst without completing partial outputs; first start after rst release SHALL run a full N_IN*N_OUT sequence.

Configuration
REQ-024 SHALL support macro FC_SATURATE_EN selecting result reduction.
REQ-025 SHALL, with FC_SATURATE_EN undefined, keep the low BITWIDTH bits of the shifted accumulator (two's-complement wrap).
REQ-026 SHALL, with FC_SATURATE_EN defined, clamp the shifted accumulator to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].

Verification
REQ-027 SHALL cover: all featuremap=65536, all weights=65536, start -> out_valid after exactly 100 cycles, every output=10, busy high 100 cycles.
REQ-028 SHALL cover: featuremap[i]=i*65536, weight[i][j]=65536 if i==j else 0 -> output_vector[j]=j for j=0..9.
REQ-029 SHALL cover: featuremap[0]=-65536, weight[0][j]=65536, all else 0 -> every output=-1 (arithmetic shift).
REQ-030 SHALL cover: all featuremap and weights=0x7FFFFFFF -> outputs 0x7FFFFFF6 without FC_SATURATE_EN, 0x7FFFFFFF with it.
REQ-031 SHALL cover: rst pulsed at MAC cycle 50 -> busy=0, out_valid=0, outputs all 0 at once; next start yields REQ-027 results after 100 cycles.
REQ-032 SHALL cover: out_ready held low 20 cycles in HOLD with start pulsed -> out_valid and outputs unchanged, start ignored; out_ready high -> IDLE next edge.
